generador_pulsos: RTL and testbench

GENERADOR_PULSOS -- requirements
Module: generador_pulsos

---
 rtl/generador_pulsos_pkg.sv | 22 ++
 rtl/generador_pulsos_canal.sv | 113 +++++++++++
 rtl/generador_pulsos.sv | 34 +++
 tb/tb_generador_pulsos.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/generador_pulsos_pkg.sv
// Shared definitions for the press/pulse generator: channel state encoding
// and the counter-width helper.
package generador_pulsos_pkg;

  typedef enum logic [2:0] {
    ESPERA   = 3'd0,
    FILTRO   = 3'd1,
    PULSO    = 3'd2,
    RETENIDO = 3'd3,
    REPITE   = 3'd4
  } estado_t;

  // Bits needed to hold the largest of the three timing constants.
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/generador_pulsos_canal.sv
// One channel: 2-flop synchroniser, debounce filter and one-shot /
// auto-repeat pulse FSM. Outputs are registered copies of the next state.
module generador_pulsos_canal
  import generador_pulsos_pkg::*;
#(
  parameter int DEB_CYC = 4,
  parameter int REP_DLY = 8,
  parameter int REP_PER = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic activar,
  input  logic modo,
  output logic suma,
  output logic pulsado
);

  localparam int CW = cnt_w(DEB_CYC, REP_DLY, REP_PER);
  // Terminal counts: the FSM spends (N-1) counted cycles before the pulse.
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(REP_DLY - 2);
  localparam logic [CW-1:0] PER_LAST = CW'(REP_PER - 2);

  logic [1:0]    sinc;
  logic          act_s;
  estado_t       estado, estado_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          rep, rep_nx;

  assign act_s = sinc[1];

  always_comb begin
    estado_nx = estado;
    cnt_nx    = cnt;
    rep_nx    = rep;
    case (estado)
      ESPERA: begin
        if (act_s) begin
          estado_nx = (DEB_CYC == 1) ? PULSO : FILTRO;
          cnt_nx    = CW'(1);
        end
      end
      FILTRO: begin
        if (!act_s) begin
          estado_nx = ESPERA;
          cnt_nx    = '0;
          rep_nx    = 1'b0;
        end else if (cnt == DEB_LAST) begin
          estado_nx = PULSO;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      PULSO: begin
        cnt_nx = '0;
        if (!act_s) begin
          estado_nx = ESPERA;
          rep_nx    = 1'b0;
        end else begin
          estado_nx = rep ? REPITE : RETENIDO;
        end
      end
      RETENIDO: begin
        if (!act_s) begin
          estado_nx = ESPERA;
          cnt_nx    = '0;
          rep_nx    = 1'b0;
        end else if (modo) begin
          if (cnt == DLY_LAST) begin
            estado_nx = PULSO;
            rep_nx    = 1'b1;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      REPITE: begin
        if (!act_s) begin
          estado_nx = ESPERA;
          cnt_nx    = '0;
          rep_nx    = 1'b0;
        end else if (modo) begin
          if (cnt == PER_LAST) estado_nx = PULSO;
          else                 cnt_nx    = cnt + 1'b1;
        end
      end
      default: begin
        estado_nx = ESPERA;
        cnt_nx    = '0;
        rep_nx    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sinc    <= '0;
      estado  <= ESPERA;
      cnt     <= '0;
      rep     <= 1'b0;
      suma    <= 1'b0;
      pulsado <= 1'b0;
    end else begin
      sinc    <= {sinc[0], activar};
      estado  <= estado_nx;
      cnt     <= cnt_nx;
      rep     <= rep_nx;
      suma    <= (estado_nx == PULSO);
      pulsado <= (estado_nx == PULSO) || (estado_nx == RETENIDO) || (estado_nx == REPITE);
    end
  end

endmodule

// File: rtl/generador_pulsos.sv
// Multi-channel debounced press-to-pulse generator; channels are fully
// independent copies of generador_pulsos_canal.
module generador_pulsos
  import generador_pulsos_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int DEB_CYC = 4,
  parameter int REP_DLY = 8,
  parameter int REP_PER = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] activar,
  input  logic [N_CH-1:0] modo,
  output logic [N_CH-1:0] suma,
  output logic [N_CH-1:0] pulsado
);

  for (genvar c = 0; c < N_CH; c++) begin : g_canal
    generador_pulsos_canal #(
      .DEB_CYC(DEB_CYC),
      .REP_DLY(REP_DLY),
      .REP_PER(REP_PER)
    ) u_canal (
      .clk    (clk),
      .reset  (reset),
      .activar(activar[c]),
      .modo   (modo[c]),
      .suma   (suma[c]),
      .pulsado(pulsado[c])
    );
  end

endmodule

// File: tb/tb_generador_pulsos.sv
// Bench for generador_pulsos: directed scenarios plus random presses,
// every cycle compared against a press/hold/repeat reference model.
module tb_generador_pulsos;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int DLY = 8;
  localparam int PER = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] activar, modo;
  logic [N-1:0] suma, pulsado;

  int ncmp = 0, nerr = 0, cyc = 0;

  // reference model state
  bit   [N-1:0] m_s1, m_s2;
  int           run [N];
  int           elapsed [N];
  int           npul [N];
  bit           held [N];
  logic [N-1:0] exp_suma, exp_pulsado;

  // observed pulse bookkeeping
  int cnt_p [N];
  int first_p [N];
  int last_p [N];
  int pq2 [$];
  int pq3 [$];

  generador_pulsos #(.N_CH(N), .DEB_CYC(DEB), .REP_DLY(DLY), .REP_PER(PER)) dut (
    .clk    (clk),
    .reset  (reset),
    .activar(activar),
    .modo   (modo),
    .suma   (suma),
    .pulsado(pulsado)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0;
    m_s2 = '0;
    exp_suma = '0;
    exp_pulsado = '0;
    for (int c = 0; c < N; c++) begin
      run[c] = 0; elapsed[c] = 0; npul[c] = 0; held[c] = 1'b0;
    end
  endtask

  // A press is accepted on its DEB-th consecutive synchronised high sample.
  // After each pulse, the edge leaving the pulse always counts; later edges
  // count only with modo=1. The next pulse fires once DLY (first gap) or
  // PER (later gaps) edges have been counted.
  task automatic model_edge();
    for (int c = 0; c < N; c++) begin
      exp_suma[c] = 1'b0;
      if (!m_s2[c]) begin
        run[c]  = 0;
        held[c] = 1'b0;
      end else if (!held[c]) begin
        run[c]++;
        if (run[c] == DEB) begin
          held[c] = 1'b1; exp_suma[c] = 1'b1; elapsed[c] = 0; npul[c] = 1;
        end
      end else begin
        if (elapsed[c] == 0 || modo[c]) elapsed[c]++;
        if (elapsed[c] == ((npul[c] == 1) ? DLY : PER)) begin
          exp_suma[c] = 1'b1; elapsed[c] = 0; npul[c]++;
        end
      end
      exp_pulsado[c] = held[c];
    end
    m_s2 = m_s1;
    m_s1 = activar;
  endtask

  task automatic reset_obs();
    for (int c = 0; c < N; c++) begin
      cnt_p[c] = 0; first_p[c] = -1; last_p[c] = -1;
    end
    pq2.delete();
    pq3.delete();
  endtask

  task automatic check_outputs();
    chk("suma", 32'(suma), 32'(exp_suma));
    chk("pulsado", 32'(pulsado), 32'(exp_pulsado));
    for (int c = 0; c < N; c++) begin
      if (suma[c] === 1'b1) begin
        cnt_p[c]++;
        last_p[c] = cyc;
        if (first_p[c] < 0) first_p[c] = cyc;
      end
    end
    if (suma[2] === 1'b1) pq2.push_back(cyc);
    if (suma[3] === 1'b1) pq3.push_back(cyc);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      if (reset) model_edge();
      @(negedge clk);
      cyc++;
      check_outputs();
    end
  endtask

  initial begin
    int t0, rel, p, nxt, base, lat, found;
    bit pat [5];

    reset = 1'b0; activar = '0; modo = '0;
    model_reset();
    reset_obs();
    #3;
    chk("rst_suma", 32'(suma), 0);
    chk("rst_pulsado", 32'(pulsado), 0);
    activar = '1;
    #20;
    chk("rst_held_suma", 32'(suma), 0);
    chk("rst_held_pulsado", 32'(pulsado), 0);
    activar = '0;
    @(negedge clk);
    reset = 1'b1;
    step(4);

    // clean one-shot press on ch0
    reset_obs();
    t0 = cyc;
    activar[0] = 1'b1;
    step(30);
    chk("clean_lat", first_p[0] - t0, DEB + 2);
    activar[0] = 1'b0;
    step(2);
    chk("clean_hold", 32'(pulsado[0]), 1);
    step(1);
    chk("clean_rel", 32'(pulsado[0]), 0);
    step(4);
    chk("clean_cnt", cnt_p[0], 1);

    // bouncing press on ch1
    reset_obs();
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      activar[1] = pat[i];
      step(1);
    end
    activar[1] = 1'b1;
    t0 = cyc;
    step(20);
    lat = first_p[1] - t0;
    chk("bounce_lat", 32'((lat == DEB + 2) || (lat == DEB + 3)), 1);
    chk("bounce_cnt", cnt_p[1], 1);
    activar[1] = 1'b0;
    step(5);

    // auto-repeat on ch2
    reset_obs();
    modo[2] = 1'b1;
    activar[2] = 1'b1;
    step(40);
    activar[2] = 1'b0;
    rel = cyc;
    step(8);
    chk("rep_count_ok", 32'(pq2.size() >= 5), 1);
    if (pq2.size() >= 3) begin
      chk("rep_dly", pq2[1] - pq2[0], DLY);
      for (int i = 2; i < pq2.size(); i++) chk("rep_per", pq2[i] - pq2[i-1], PER);
      chk("rep_stop", 32'(pq2[pq2.size()-1] <= rel + 3), 1);
    end
    modo[2] = 1'b0;

    // simultaneous press, ch3 repeating with a 10-cycle modo pause
    reset_obs();
    modo = 4'b1000;
    activar = '1;
    step(12);
    chk("simul_seen", 32'(first_p[0] >= 0), 1);
    for (int c = 1; c < N; c++) chk("simul_first", first_p[c], first_p[0]);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      step(1);
      if (suma[3] === 1'b1) found = 1;
    end
    chk("wait_p3", found, 1);
    p = cyc;
    step(1);
    modo[3] = 1'b0;
    step(10);
    modo[3] = 1'b1;
    step(12);
    nxt = -1;
    foreach (pq3[i]) if (nxt < 0 && pq3[i] > p) nxt = pq3[i];
    chk("pause_gap", nxt - p, PER + 10);
    chk("oneshot_cnt", cnt_p[0], 1);
    activar = '0;
    modo = '0;
    step(6);

    // reset during the pulse cycle with the press still held
    reset_obs();
    activar[0] = 1'b1;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      step(1);
      if (suma[0] === 1'b1) found = 1;
    end
    chk("wait_p0", found, 1);
    reset = 1'b0;
    model_reset();
    #1;
    chk("midrst_suma", 32'(suma), 0);
    chk("midrst_pulsado", 32'(pulsado), 0);
    step(1);
    reset = 1'b1;
    base = cnt_p[0];
    t0 = cyc;
    step(14);
    chk("postrst_cnt", cnt_p[0] - base, 1);
    chk("postrst_lat", last_p[0] - t0, DEB + 2);
    activar[0] = 1'b0;
    step(6);

    // random presses, bounce, mode changes and occasional resets
    for (int i = 0; i < 500; i++) begin
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 7) == 0) activar[c] = ~activar[c];
        if ($urandom_range(0, 15) == 0) modo[c] = ~modo[c];
      end
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b0;
        model_reset();
        #1;
        chk("rnd_rst_suma", 32'(suma), 0);
        step(1);
        reset = 1'b1;
      end
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
